// File: rtl/msg_arb.sv
// msg_arb: grants one message source at a time to the shared line coder and
// moves that source's bytes into the coder under the coder's busy handshake.
// Source 0 (time-mark) has strict priority; sources 1..N-1 share round-robin.
module msg_arb #(
    parameter int N          = 3,
    parameter int TMO_CYCLES = 1024,
    parameter int GAP_CYCLES = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req,
    output logic [N-1:0]   tx_en,
    input  logic [8*N-1:0] src_q,
    input  logic [N-1:0]   src_q_rdy,
    input  logic [N-1:0]   src_last,
    input  logic           cd_busy,
    output logic [7:0]     cd_q,
    output logic           cd_wr,
    output logic [2:0]     grant_id,
    output logic           msg_done,
    output logic           err
);

    // One counter serves both the wait-state timeout and the inter-message gap.
    localparam int CNT_MAX = (TMO_CYCLES > GAP_CYCLES) ? TMO_CYCLES : GAP_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_ACK_HI,
        S_ACK_LO,
        S_GAP
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       rr_ptr_q, rr_ptr_d;
    logic             last_q, last_d;
    logic [N-1:0]     tx_en_q, tx_en_d;
    logic [7:0]       cd_q_q, cd_q_d;
    logic             cd_wr_q, cd_wr_d;
    logic [2:0]       grant_id_q, grant_id_d;
    logic             msg_done_q, msg_done_d;
    logic             err_q, err_d;

    // Per-source inputs padded out to 8 entries so a 3-bit index selects exactly.
    logic [7:0] req_ext;
    logic [7:0] rdy_ext;
    logic [7:0] last_ext;
    logic [7:0] src_byte [8];

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_ext
            if (gi < N) begin : g_src
                assign req_ext[gi]  = req[gi];
                assign rdy_ext[gi]  = src_q_rdy[gi];
                assign last_ext[gi] = src_last[gi];
                assign src_byte[gi] = src_q[8*gi +: 8];
            end else begin : g_pad
                assign req_ext[gi]  = 1'b0;
                assign rdy_ext[gi]  = 1'b0;
                assign last_ext[gi] = 1'b0;
                assign src_byte[gi] = 8'h00;
            end
        end
    endgenerate

    logic       win_found;
    logic [2:0] win_id;
    logic [2:0] cand;

    // Winner selection: source 0 first, else scan 1..N-1 starting after rr_ptr.
    always_comb begin
        win_found = 1'b0;
        win_id    = 3'd0;
        cand      = 3'd0;
        if (req_ext[0]) begin
            win_found = 1'b1;
            win_id    = 3'd0;
        end else begin
            for (int k = 1; k < N; k++) begin
                cand = 3'((((int'(rr_ptr_q) - 1) + k) % (N - 1)) + 1);
                if (!win_found && req_ext[cand]) begin
                    win_found = 1'b1;
                    win_id    = cand;
                end
            end
        end
    end

    logic tmo_hit;
    logic abort;

    // Next-state and registered-output logic; exit conditions beat the timeout.
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        last_d     = last_q;
        tx_en_d    = tx_en_q;
        cd_q_d     = cd_q_q;
        cd_wr_d    = 1'b0;
        grant_id_d = grant_id_q;
        msg_done_d = 1'b0;
        err_d      = 1'b0;
        abort      = 1'b0;
        tmo_hit    = (cnt_q == CNT_W'(TMO_CYCLES - 1));

        case (state_q)
            S_IDLE: begin
                tx_en_d = '0;
                if (win_found) begin
                    state_d    = S_ARM;
                    grant_id_d = win_id;
                    tx_en_d    = N'(8'b1 << win_id);
                    if (win_id != 3'd0) begin
                        rr_ptr_d = win_id;
                    end
                end
            end
            S_ARM: begin
                if (!cd_busy && rdy_ext[grant_id_q]) begin
                    cd_q_d  = src_byte[grant_id_q];
                    cd_wr_d = 1'b1;
                    last_d  = last_ext[grant_id_q];
                    state_d = S_ACK_HI;
                end else if (tmo_hit) begin
                    abort = 1'b1;
                end
            end
            S_ACK_HI: begin
                if (cd_busy) begin
                    state_d = S_ACK_LO;
                end else if (tmo_hit) begin
                    abort = 1'b1;
                end
            end
            S_ACK_LO: begin
                if (!cd_busy) begin
                    if (last_q) begin
                        msg_done_d = 1'b1;
                        tx_en_d    = '0;
                        state_d    = S_GAP;
                    end else begin
                        state_d = S_ARM;
                    end
                end else if (tmo_hit) begin
                    abort = 1'b1;
                end
            end
            S_GAP: begin
                tx_en_d = '0;
                if (cnt_q == CNT_W'(GAP_CYCLES - 1)) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                tx_en_d = '0;
            end
        endcase

        if (abort) begin
            err_d   = 1'b1;
            tx_en_d = '0;
            last_d  = 1'b0;
            state_d = S_GAP;
        end

        // Counter restarts on every state entry and idles at zero in IDLE.
        if (state_d != state_q || state_q == S_IDLE) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            rr_ptr_q   <= 3'(N - 1);
            last_q     <= 1'b0;
            tx_en_q    <= '0;
            cd_q_q     <= 8'h00;
            cd_wr_q    <= 1'b0;
            grant_id_q <= 3'd0;
            msg_done_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rr_ptr_q   <= rr_ptr_d;
            last_q     <= last_d;
            tx_en_q    <= tx_en_d;
            cd_q_q     <= cd_q_d;
            cd_wr_q    <= cd_wr_d;
            grant_id_q <= grant_id_d;
            msg_done_q <= msg_done_d;
            err_q      <= err_d;
        end
    end

    assign tx_en    = tx_en_q;
    assign cd_q     = cd_q_q;
    assign cd_wr    = cd_wr_q;
    assign grant_id = grant_id_q;
    assign msg_done = msg_done_q;
    assign err      = err_q;

endmodule

// File: tb/tb_msg_arb.sv
// tb_msg_arb: directed bench for msg_arb with a behavioural coder and
// byte-serving source models; expected grants and bytes are hand-computed.
module tb_msg_arb;

    localparam int N   = 3;
    localparam int TMO = 16;
    localparam int GAP = 2;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   req = '0;
    logic [N-1:0]   tx_en;
    logic [8*N-1:0] src_q = '0;
    logic [N-1:0]   src_q_rdy = '0;
    logic [N-1:0]   src_last = '0;
    logic           cd_busy = 1'b0;
    logic [7:0]     cd_q;
    logic           cd_wr;
    logic [2:0]     grant_id;
    logic           msg_done;
    logic           err;

    msg_arb #(.N(N), .TMO_CYCLES(TMO), .GAP_CYCLES(GAP)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .tx_en     (tx_en),
        .src_q     (src_q),
        .src_q_rdy (src_q_rdy),
        .src_last  (src_last),
        .cd_busy   (cd_busy),
        .cd_q      (cd_q),
        .cd_wr     (cd_wr),
        .grant_id  (grant_id),
        .msg_done  (msg_done),
        .err       (err)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Source message contents
    logic [7:0] msg_bytes [N][4];
    int         msg_len [N];
    int         ptr [N];

    // Coder model and monitor state
    int         busy_len = 1;
    int         bcnt = 0;
    logic       coder_on = 1'b1;
    logic [7:0] wr_log [$];
    int         grants [$];
    int         done_cnt = 0;
    int         err_cnt = 0;
    logic [N-1:0] prev_tx = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Coder, sources and monitor all act on the falling edge
    always @(negedge clk) begin
        if (rst) begin
            cd_busy = 1'b0;
            bcnt    = 0;
        end else if (cd_wr) begin
            chk("wr_while_busy", {31'd0, cd_busy}, 32'd0);
            wr_log.push_back(cd_q);
            if (coder_on) begin
                cd_busy = 1'b1;
                bcnt    = busy_len;
            end
        end else if (bcnt > 0) begin
            bcnt--;
            if (bcnt == 0) cd_busy = 1'b0;
        end
        for (int i = 0; i < N; i++) begin
            if (!tx_en[i]) ptr[i] = 0;
            else if (cd_wr) ptr[i]++;
            src_q_rdy[i] = tx_en[i] && (ptr[i] < msg_len[i]);
            src_last[i]  = (ptr[i] == msg_len[i] - 1);
            src_q[8*i +: 8] = msg_bytes[i][(ptr[i] < 4) ? ptr[i] : 0];
        end
        if (msg_done === 1'b1) done_cnt++;
        if (err === 1'b1) err_cnt++;
        if (tx_en != '0 && prev_tx == '0) begin
            for (int i = 0; i < N; i++) if (tx_en[i]) grants.push_back(i);
        end
        prev_tx = tx_en;
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_logs();
        wr_log.delete();
        grants.delete();
        done_cnt = 0;
        err_cnt  = 0;
    endtask

    task automatic wait_release();
        int k;
        k = 0;
        while (tx_en != '0 && k < 400) begin step(); k++; end
        chk("release", {31'd0, tx_en == '0}, 32'd1);
        repeat (GAP + 2) step();
    endtask

    // One complete message from request to release, checked end to end
    task automatic run_msg(input logic [2:0] rq, input int bl, input logic [2:0] gid,
                           input int n, input logic [7:0] fb, input logic [7:0] lb);
        int k;
        logic [7:0] af, al;
        busy_len = bl;
        clear_logs();
        req = rq[N-1:0];
        k = 0;
        while (tx_en == '0 && k < 20) begin step(); k++; end
        chk("grant_seen", {31'd0, tx_en != '0}, 32'd1);
        chk("tx_en", 32'(tx_en), 32'(1 << gid));
        chk("grant_id", 32'(grant_id), 32'(gid));
        req = '0;
        wait_release();
        af = (wr_log.size() > 0) ? wr_log[0] : 8'hxx;
        al = (wr_log.size() > 0) ? wr_log[wr_log.size()-1] : 8'hxx;
        chk("nbytes", wr_log.size(), n);
        chk("first_byte", 32'(af), 32'(fb));
        chk("last_byte", 32'(al), 32'(lb));
        chk("done_cnt", done_cnt, 1);
        chk("err_cnt", err_cnt, 0);
        $display("msg req=%b gid=%0d bytes=%0d first=%h last=%h done=%0d err=%0d",
                 rq, grant_id, wr_log.size(), af, al, done_cnt, err_cnt);
    endtask

    typedef struct {
        logic [2:0] rq;
        int         bl;
        logic [2:0] gid;
        int         n;
        logic [7:0] fb;
        logic [7:0] lb;
    } vec_t;

    vec_t vecs [11];
    int   exp_order [7];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, bad_en;
        msg_bytes[0][0] = 8'hA5; msg_bytes[0][1] = 8'h3C; msg_bytes[0][2] = 8'h00; msg_bytes[0][3] = 8'h00;
        msg_bytes[1][0] = 8'h11; msg_bytes[1][1] = 8'h22; msg_bytes[1][2] = 8'h33; msg_bytes[1][3] = 8'h00;
        msg_bytes[2][0] = 8'hC7; msg_bytes[2][1] = 8'h00; msg_bytes[2][2] = 8'h00; msg_bytes[2][3] = 8'h00;
        msg_len[0] = 2; msg_len[1] = 3; msg_len[2] = 1;
        for (int i = 0; i < N; i++) ptr[i] = 0;

        // round-robin pointer starts at 2 after the source-0 test
        vecs[0]  = '{3'b001, 4, 3'd0, 2, 8'hA5, 8'h3C};
        vecs[1]  = '{3'b110, 1, 3'd1, 3, 8'h11, 8'h33};
        vecs[2]  = '{3'b110, 2, 3'd2, 1, 8'hC7, 8'hC7};
        vecs[3]  = '{3'b111, 3, 3'd0, 2, 8'hA5, 8'h3C};
        vecs[4]  = '{3'b110, 1, 3'd1, 3, 8'h11, 8'h33};
        vecs[5]  = '{3'b100, 2, 3'd2, 1, 8'hC7, 8'hC7};
        vecs[6]  = '{3'b100, 1, 3'd2, 1, 8'hC7, 8'hC7};
        vecs[7]  = '{3'b110, 3, 3'd1, 3, 8'h11, 8'h33};
        vecs[8]  = '{3'b010, 1, 3'd1, 3, 8'h11, 8'h33};
        vecs[9]  = '{3'b110, 2, 3'd2, 1, 8'hC7, 8'hC7};
        vecs[10] = '{3'b011, 1, 3'd0, 2, 8'hA5, 8'h3C};
        exp_order = '{0, 0, 0, 1, 2, 1, 2};

        // Reset state
        rst = 1'b1;
        repeat (3) step();
        chk("rst_tx_en", 32'(tx_en), 0);
        chk("rst_cd_q", 32'(cd_q), 0);
        chk("rst_cd_wr", 32'(cd_wr), 0);
        chk("rst_grant_id", 32'(grant_id), 0);
        chk("rst_msg_done", 32'(msg_done), 0);
        chk("rst_err", 32'(err), 0);
        rst = 1'b0;
        step();

        // Source 0, two bytes, coder busy 4 cycles; request held to time regrant
        busy_len = 4;
        clear_logs();
        req = 3'b001;
        step();
        chk("grant_latency", 32'(tx_en), 32'b001);
        chk("grant_id_src0", 32'(grant_id), 0);
        bad_en = 0;
        k = 0;
        while (msg_done !== 1'b1 && k < 200) begin
            if (tx_en !== 3'b001) bad_en++;
            step();
            k++;
        end
        chk("msg_done_seen", 32'(msg_done), 1);
        chk("tx_en_low_at_done", 32'(tx_en), 0);
        chk("tx_en_held", bad_en, 0);
        chk("src0_nbytes", wr_log.size(), 2);
        if (wr_log.size() == 2) begin
            chk("src0_byte0", 32'(wr_log[0]), 32'h A5);
            chk("src0_byte1", 32'(wr_log[1]), 32'h 3C);
        end
        k = 0;
        while (tx_en == '0 && k < 20) begin step(); k++; end
        chk("regrant_gap", k, GAP + 1);
        req = '0;
        wait_release();
        chk("src0_done_twice", done_cnt, 2);
        $display("msg src0 held: bytes=%0d done=%0d regrant_after=%0d", wr_log.size(), done_cnt, k);

        // Table of single messages
        for (int v = 0; v < 11; v++) begin
            run_msg(vecs[v].rq, vecs[v].bl, vecs[v].gid, vecs[v].n, vecs[v].fb, vecs[v].lb);
        end

        // Contention after a fresh reset: source 0 dominates, then 1/2 alternate
        rst = 1'b1;
        repeat (2) step();
        rst = 1'b0;
        step();
        busy_len = 1;
        clear_logs();
        req = 3'b111;
        k = 0;
        while (grants.size() < 3 && k < 300) begin step(); k++; end
        req = 3'b110;
        k = 0;
        while (grants.size() < 7 && k < 300) begin step(); k++; end
        req = '0;
        wait_release();
        chk("contention_ngrants", grants.size(), 7);
        for (int i = 0; i < 7; i++) begin
            if (i < grants.size()) chk("grant_order", grants[i], exp_order[i]);
        end
        $display("contention grants=%0d", grants.size());

        // Coder never goes busy: timeout
        coder_on = 1'b0;
        busy_len = 1;
        clear_logs();
        req = 3'b010;
        k = 0;
        while (tx_en == '0 && k < 20) begin step(); k++; end
        req = '0;
        k = 0;
        while (cd_wr !== 1'b1 && k < 50) begin step(); k++; end
        chk("tmo_write_seen", 32'(cd_wr), 1);
        k = 0;
        while (err !== 1'b1 && k < TMO + 20) begin step(); k++; end
        chk("tmo_latency", k, TMO);
        chk("tmo_tx_en_clear", 32'(tx_en), 0);
        chk("tmo_no_done", 32'(msg_done), 0);
        repeat (GAP + 2) step();
        chk("tmo_err_cnt", err_cnt, 1);
        chk("tmo_done_cnt", done_cnt, 0);
        chk("tmo_nbytes", wr_log.size(), 1);
        $display("timeout latency=%0d err=%0d done=%0d", k, err_cnt, done_cnt);
        coder_on = 1'b1;
        run_msg(3'b100, 2, 3'd2, 1, 8'hC7, 8'hC7);

        // Reset in ACK_LO with the request still pending
        busy_len = 4;
        clear_logs();
        req = 3'b010;
        k = 0;
        while (tx_en == '0 && k < 20) begin step(); k++; end
        k = 0;
        while (cd_busy !== 1'b1 && k < 50) begin step(); k++; end
        chk("rstmid_busy_seen", 32'(cd_busy), 1);
        rst = 1'b1;
        step();
        chk("rstmid_tx_en", 32'(tx_en), 0);
        chk("rstmid_cd_q", 32'(cd_q), 0);
        chk("rstmid_cd_wr", 32'(cd_wr), 0);
        chk("rstmid_grant_id", 32'(grant_id), 0);
        chk("rstmid_msg_done", 32'(msg_done), 0);
        chk("rstmid_err", 32'(err), 0);
        rst = 1'b0;
        step();
        chk("rstmid_regrant", 32'(tx_en), 32'b010);
        chk("rstmid_regrant_id", 32'(grant_id), 1);
        req = '0;
        wait_release();
        chk("rstmid_done_cnt", done_cnt, 1);
        chk("rstmid_err_cnt", err_cnt, 0);
        $display("reset-mid-message done=%0d err=%0d writes=%0d", done_cnt, err_cnt, wr_log.size());

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
